// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Holds the arbiter FSM state encoding and the default parameter values.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first unmasked request at or after start.
// Ports: req/mask (NUM_REQ), start (ID_WIDTH) -> found, index (ID_WIDTH).
module rr_priority_picker #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] start,
    input  logic [NUM_REQ-1:0]  mask,
    output logic                found,
    output logic [ID_WIDTH-1:0] index
);

    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & ~mask;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        logic [ID_WIDTH-1:0] idx;
        idx   = '0;
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(start) + k) % NUM_REQ);
            if (eligible[idx]) begin
                found = 1'b1;
                index = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo_buffer write port among NUM_REQ
// producers, granting bursts of up to BURST_LEN beats and honouring full.
// Ports: clk, reset (async, high); req_valid/req_data/req_ready per
// producer; full from the FIFO; wr_en/wr_data to the FIFO; grant_id, busy.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int CNT_WIDTH = $clog2(BURST_LEN + 1);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic [ID_WIDTH-1:0] rr_ptr_nxt;
    logic [ID_WIDTH-1:0] grant_nxt;
    logic [CNT_WIDTH-1:0] beat_cnt;
    logic [CNT_WIDTH-1:0] beat_cnt_nxt;

    logic                g_valid;
    logic                transfer;
    logic                rel_burst;
    logic                rel_drop;
    logic [ID_WIDTH-1:0] ptr_inc;
    logic [NUM_REQ-1:0]  g_onehot;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [ID_WIDTH-1:0] pick_start;
    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_idx;

    assign g_valid   = req_valid[grant_id];
    assign transfer  = (state == GRANT) && g_valid && !full;
    assign rel_burst = transfer &&
                       (beat_cnt == CNT_WIDTH'(BURST_LEN - 1));
    assign rel_drop  = (state == GRANT) && !g_valid;

    // Explicit wrap keeps rr_ptr legal when NUM_REQ is not a power of 2.
    assign ptr_inc = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ?
                     '0 : grant_id + 1'b1;

    assign g_onehot = NUM_REQ'(1) << grant_id;

    // A finished burst only steps aside if someone else is waiting;
    // otherwise the same producer is re-picked for the next burst.
    assign pick_mask = (rel_burst && |(req_valid & ~g_onehot)) ?
                       g_onehot : '0;

    // While granted the picker only matters on release, which uses g+1.
    assign pick_start = (state == GRANT) ? ptr_inc : rr_ptr;

    rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .req   (req_valid),
        .start (pick_start),
        .mask  (pick_mask),
        .found (pick_found),
        .index (pick_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_cnt_nxt;
            grant_id <= grant_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        beat_cnt_nxt = beat_cnt;
        grant_nxt    = grant_id;
        unique case (state)
            IDLE: begin
                beat_cnt_nxt = '0;
                if (pick_found) begin
                    state_nxt = GRANT;
                    grant_nxt = pick_idx;
                end
            end
            GRANT: begin
                if (rel_burst || rel_drop) begin
                    rr_ptr_nxt = ptr_inc;
                    beat_cnt_nxt = '0;
                    if (pick_found) begin
                        grant_nxt = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (transfer) begin
                    beat_cnt_nxt = beat_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        busy      = 1'b0;
        if (state == GRANT) begin
            busy                = 1'b1;
            req_ready[grant_id] = !full;
            wr_en               = g_valid && !full;
            wr_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule
